ides4_align_ctrl: RTL and testbench
===================================

IDES4_ALIGN_CTRL -- requirements
Module: ides4_align_ctrl

Interface
REQ-001 SHALL have parameter PATTERN, default 4'b0011: training word expected on q_i once aligned.
REQ-002 SHALL have parameter SETTLE_CYC, default 3: wait cycles after each CALIB pulse before checking, range 1..15.
REQ-003 SHALL have parameter MATCH_CNT, default 8: consecutive matching words required for lock, range 1..255.
REQ-004 SHALL have parameter MAX_TRIES, default 8: CALIB pulses allowed before failure, range 1..255.
REQ-005 SHALL have parameter LOSS_CNT, default 4: consecutive mismatches in LOCKED that count as loss of lock, range 1..255.
REQ-006 SHALL have port clk, input, 1 bit: the IDES4 PCLK domain; all logic is on its rising edge.
REQ-007 SHALL have port rst_i, input, 1 bit: reset, asynchronous assert, active-low, synchronous deassert by the caller.
REQ-008 SHALL have port start_i, input, 1 bit: level-sampled request to begin alignment.
REQ-009 SHALL have port q_i, input, 4 bits: IDES4 Q3..Q0 word, with Q0 as bit 0.
REQ-010 SHALL have port calib_o, output, 1 bit: drives IDES4 CALIB.
REQ-011 SHALL have port busy_o, output, 1 bit: high while in PULSE, SETTLE or CHECK.
REQ-012 SHALL have port aligned_o, output, 1 bit: high only in LOCKED.
REQ-013 SHALL have port fail_o, output, 1 bit: high only in FAIL.
REQ-014 SHALL have port shift_o, output, 2 bits: number of CALIB pulses issued in the current attempt, modulo 4.

Function
REQ-015 SHALL use these FSM states: IDLE, PULSE, SETTLE, CHECK, LOCKED, FAIL.
REQ-016 In IDLE with start_i=1, the FSM SHALL go to CHECK; tries, match counter and shift_o are cleared.
REQ-017 PULSE SHALL last exactly 1 cycle, with calib_o=1 only in PULSE; on leaving PULSE, tries increments and shift_o increments with wrap from 3 to 0.
REQ-018 SETTLE SHALL last exactly SETTLE_CYC cycles, then the FSM goes to CHECK with the match counter cleared.
REQ-019 In CHECK, on q_i==PATTERN the match counter SHALL increment; on reaching MATCH_CNT the FSM goes to LOCKED.
REQ-020 In CHECK, on q_i!=PATTERN: if tries<MAX_TRIES the FSM SHALL go to PULSE, otherwise to FAIL.
REQ-021 As a consequence of REQ-016 to REQ-020, the first CHECK SHALL use no pulse, so already-aligned data locks after exactly MATCH_CNT cycles.
REQ-022 In LOCKED, the loss counter SHALL count consecutive mismatches and clear on any match; loss handling is given in REQ-030/031.
REQ-023 FAIL and LOCKED SHALL return to IDLE when start_i=0.
REQ-024 start_i SHALL be ignored while busy_o=1; deasserting start_i mid-alignment does not abort.
REQ-025 All counters SHALL saturate and never wrap, except shift_o.

Reset
REQ-026 rst_i=0 SHALL force, asynchronously, state=IDLE, calib_o=0, busy_o=0, aligned_o=0, fail_o=0, shift_o=0 and all counters to 0.
REQ-027 Reset asserted during PULSE SHALL drop calib_o in the same instant, with no completion of the pulse.
REQ-028 After deassertion, start_i already high SHALL start alignment on the first clock edge.

Configuration
REQ-029 SHALL be configured by the macro IDES4_ALIGN_RELOCK_EN.
REQ-030 When IDES4_ALIGN_RELOCK_EN is defined, reaching LOSS_CNT SHALL make LOCKED go to PULSE, with tries cleared and shift_o kept.
REQ-031 When IDES4_ALIGN_RELOCK_EN is undefined, reaching LOSS_CNT SHALL make LOCKED go to FAIL.

Structure
REQ-032 A shared package ides4_align_pkg SHALL hold the state enum typedef and the counter widths (8-bit tries/match/loss, 4-bit settle).
REQ-033 A single sub-module ides4_pattern_match SHALL hold the registered-free comparator plus the saturating consecutive-match counter, instantiated twice (match, loss).
REQ-034 No clock generation or division SHALL exist inside the block.

Verification
REQ-035 Bench SHALL cover: q_i fixed at 4'b0011, start_i=1 -> calib_o never pulses; aligned_o rises 8 cycles after start is seen; shift_o=0.
REQ-036 Bench SHALL cover: a bit-slip model needing 2 pulses -> exactly 2 one-cycle calib_o pulses, at least 3 cycles apart; aligned_o rises; shift_o=2.
REQ-037 Bench SHALL cover: q_i constant 4'b0000 -> 8 pulses, then fail_o=1 and busy_o=0; start_i=0 -> IDLE next cycle.
REQ-038 Bench SHALL cover: LOCKED, then 4 consecutive bad words -> with the macro, calib_o pulses and relock occurs; without it, fail_o=1; and 3 bad words then 1 good word -> lock held.
REQ-039 Bench SHALL cover: rst_i low during PULSE -> calib_o=0 immediately, all outputs at reset values; after release, realignment completes.
REQ-040 Bench SHALL cover: start_i toggled during SETTLE -> no restart; the pulse count and timing are unchanged.

Source files
------------

// File: rtl/ides4_align_pkg.sv
// Shared types and counter widths for the IDES4 word-alignment controller.
package ides4_align_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StPulse,
      StSettle,
      StCheck,
      StLocked,
      StFail
   } state_e;

   localparam int unsigned CntW    = 8;
   localparam int unsigned SettleW = 4;

   function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
      return (v == {CntW{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/ides4_pattern_match.sv
// Word comparator with a saturating count of consecutive qualifying words.
// COUNT_MISS selects whether matches or mismatches are the counted event.
module ides4_pattern_match
   import ides4_align_pkg::*;
#(
   parameter logic [3:0]  PATTERN    = 4'b0011,
   parameter bit          COUNT_MISS = 1'b0,
   parameter int unsigned TARGET     = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       en,
   input  logic [3:0] word,
   output logic       hit,
   output logic       last
);

   logic [CntW-1:0] cnt_q, cnt_d;

   assign hit  = en & ((word == PATTERN) != COUNT_MISS);
   // One more qualifying word will reach TARGET.
   assign last = (cnt_q >= CntW'(TARGET - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = hit ? sat_inc(cnt_q) : '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/ides4_align_ctrl.sv
// IDES4 word-alignment controller: pulses CALIB until q_i shows PATTERN.
// Define IDES4_ALIGN_RELOCK_EN to realign on loss of lock instead of failing.
module ides4_align_ctrl
   import ides4_align_pkg::*;
#(
   parameter logic [3:0]  PATTERN    = 4'b0011,
   parameter int unsigned SETTLE_CYC = 3,
   parameter int unsigned MATCH_CNT  = 8,
   parameter int unsigned MAX_TRIES  = 8,
   parameter int unsigned LOSS_CNT   = 4
) (
   input  logic       clk,
   input  logic       rst_i,
   input  logic       start_i,
   input  logic [3:0] q_i,
   output logic       calib_o,
   output logic       busy_o,
   output logic       aligned_o,
   output logic       fail_o,
   output logic [1:0] shift_o
);

   state_e             state_q, state_d;
   logic [CntW-1:0]    tries_q, tries_d;
   logic [SettleW-1:0] settle_q, settle_d;
   logic [1:0]         shift_q, shift_d;
   logic               in_check, in_locked;
   logic               match_hit, match_last, loss_hit, loss_last;

   assign in_check  = (state_q == StCheck);
   assign in_locked = (state_q == StLocked);

   ides4_pattern_match #(
      .PATTERN    (PATTERN),
      .COUNT_MISS (1'b0),
      .TARGET     (MATCH_CNT)
   ) u_match (
      .clk   (clk),
      .rst_n (rst_i),
      .clr   (!in_check),
      .en    (in_check),
      .word  (q_i),
      .hit   (match_hit),
      .last  (match_last)
   );

   ides4_pattern_match #(
      .PATTERN    (PATTERN),
      .COUNT_MISS (1'b1),
      .TARGET     (LOSS_CNT)
   ) u_loss (
      .clk   (clk),
      .rst_n (rst_i),
      .clr   (!in_locked),
      .en    (in_locked),
      .word  (q_i),
      .hit   (loss_hit),
      .last  (loss_last)
   );

   always_comb begin
      state_d  = state_q;
      tries_d  = tries_q;
      settle_d = settle_q;
      shift_d  = shift_q;
      unique case (state_q)
         StIdle: begin
            // The first check runs without a pulse so aligned data locks at once.
            if (start_i) begin
               state_d = StCheck;
               tries_d = '0;
               shift_d = '0;
            end
         end
         StPulse: begin
            state_d  = StSettle;
            tries_d  = sat_inc(tries_q);
            shift_d  = shift_q + 2'd1;
            settle_d = '0;
         end
         StSettle: begin
            if (settle_q == SettleW'(SETTLE_CYC - 1)) begin
               state_d = StCheck;
            end else if (settle_q != {SettleW{1'b1}}) begin
               settle_d = settle_q + 1'b1;
            end
         end
         StCheck: begin
            if (match_hit) begin
               if (match_last) state_d = StLocked;
            end else if (tries_q < CntW'(MAX_TRIES)) begin
               state_d = StPulse;
            end else begin
               state_d = StFail;
            end
         end
         StLocked: begin
            if (!start_i) begin
               state_d = StIdle;
            end else if (loss_hit && loss_last) begin
`ifdef IDES4_ALIGN_RELOCK_EN
               state_d = StPulse;
               tries_d = '0;
`else
               state_d = StFail;
`endif
            end
         end
         StFail: begin
            if (!start_i) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_i) begin
      if (!rst_i) begin
         state_q  <= StIdle;
         tries_q  <= '0;
         settle_q <= '0;
         shift_q  <= '0;
      end else begin
         state_q  <= state_d;
         tries_q  <= tries_d;
         settle_q <= settle_d;
         shift_q  <= shift_d;
      end
   end

   // Decoded straight from the state register so reset drops CALIB immediately.
   assign calib_o   = (state_q == StPulse);
   assign busy_o    = (state_q == StPulse) || (state_q == StSettle) || (state_q == StCheck);
   assign aligned_o = in_locked;
   assign fail_o    = (state_q == StFail);
   assign shift_o   = shift_q;

endmodule

// File: tb/tb_ides4_align_ctrl.sv
// Self-checking bench for ides4_align_ctrl: table vectors, directed corner cases
// and randomized slip depths checked against a timing-arithmetic model.
module tb_ides4_align_ctrl;

   localparam logic [3:0] PAT    = 4'b0011;
   localparam int         SETTLE = 3;
   localparam int         MATCH  = 8;
   localparam int         MAXT   = 8;
   localparam int         LOSS   = 4;

   logic       clk = 1'b0;
   logic       rst_i = 1'b0;
   logic       start_i = 1'b0;
   logic [3:0] q_i = PAT;
   logic       calib_o, busy_o, aligned_o, fail_o;
   logic [1:0] shift_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ides4_align_ctrl #(
      .PATTERN    (PAT),
      .SETTLE_CYC (SETTLE),
      .MATCH_CNT  (MATCH),
      .MAX_TRIES  (MAXT),
      .LOSS_CNT   (LOSS)
   ) dut (
      .clk       (clk),
      .rst_i     (rst_i),
      .start_i   (start_i),
      .q_i       (q_i),
      .calib_o   (calib_o),
      .busy_o    (busy_o),
      .aligned_o (aligned_o),
      .fail_o    (fail_o),
      .shift_o   (shift_o)
   );

   typedef struct {
      int         need;     // pulses the slip model needs before PATTERN appears
      logic       rnd;      // random bad words, else 'fill'
      logic [3:0] fill;
      logic       toggle;   // wiggle start_i during SETTLE
      int         e_pulses;
      logic       e_lock;
      int         e_cyc;    // edge index (start edge = 0) where aligned/fail rises
      int         e_shift;
   } vec_t;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [3:0] bad_word();
      logic [3:0] w;
      do w = 4'($urandom_range(0, 15)); while (w == PAT);
      return w;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, " calib"}, int'(calib_o), 0);
      check({tag, " busy"}, int'(busy_o), 0);
      check({tag, " aligned"}, int'(aligned_o), 0);
      check({tag, " fail"}, int'(fail_o), 0);
   endtask

   // Slip model: q_i shows PATTERN once 'need' CALIB pulses have been seen.
   task automatic run_align(input string tag, input int need, input logic rnd,
                            input logic [3:0] fill, input logic toggle,
                            output int pulses, output logic locked,
                            output int cyc_end, output int shift_seen);
      int   last = -100;
      logic prev_cal = 1'b0;
      logic spacing_ok = 1'b1;
      logic busy_ok = 1'b1;
      logic done = 1'b0;
      pulses = 0; locked = 1'b0; cyc_end = -1; shift_seen = -1;
      q_i = (need == 0) ? PAT : (rnd ? bad_word() : fill);
      start_i = 1'b1;
      for (int cyc = 0; cyc < 400 && !done; cyc++) begin
         tick();
         if (calib_o) begin
            if (prev_cal || (cyc - last) < 3) spacing_ok = 1'b0;
            pulses++;
            last = cyc;
         end
         prev_cal = calib_o;
         if (aligned_o || fail_o) begin
            done = 1'b1;
            locked = aligned_o;
            cyc_end = cyc;
            shift_seen = int'(shift_o);
            check({tag, " busy at end"}, int'(busy_o), 0);
         end else if (!busy_o) begin
            busy_ok = 1'b0;
         end
         if (pulses >= need) q_i = PAT;
         else q_i = rnd ? bad_word() : fill;
         if (toggle && pulses > 0 && (cyc - last) <= SETTLE) start_i = ((cyc - last) % 2 == 1);
         else start_i = 1'b1;
      end
      if (!done) check({tag, " timeout"}, 0, 1);
      check({tag, " pulse spacing"}, int'(spacing_ok), 1);
      check({tag, " busy during align"}, int'(busy_ok), 1);
   endtask

   task automatic end_run(input string tag);
      start_i = 1'b0;
      tick();
      check_idle({tag, " idle after stop"});
   endtask

   task automatic apply(input string tag, input vec_t v);
      int   p, c, s;
      logic l;
      run_align(tag, v.need, v.rnd, v.fill, v.toggle, p, l, c, s);
      check({tag, " pulses"}, p, v.e_pulses);
      check({tag, " locked"}, int'(l), int'(v.e_lock));
      check({tag, " end cycle"}, c, v.e_cyc);
      check({tag, " shift"}, s, v.e_shift);
      end_run(tag);
   endtask

   initial begin
      vec_t tbl[6];
      int   p, c, s, n;
      logic l;
      logic seen;

      tbl[0] = '{need: 0, rnd: 1'b1, fill: 4'h0, toggle: 1'b0,
                 e_pulses: 0, e_lock: 1'b1, e_cyc: 8, e_shift: 0};
      tbl[1] = '{need: 2, rnd: 1'b1, fill: 4'h0, toggle: 1'b0,
                 e_pulses: 2, e_lock: 1'b1, e_cyc: 18, e_shift: 2};
      tbl[2] = '{need: 99, rnd: 1'b0, fill: 4'b0000, toggle: 1'b0,
                 e_pulses: 8, e_lock: 1'b0, e_cyc: 41, e_shift: 0};
      tbl[3] = '{need: 4, rnd: 1'b1, fill: 4'h0, toggle: 1'b0,
                 e_pulses: 4, e_lock: 1'b1, e_cyc: 28, e_shift: 0};
      tbl[4] = '{need: 8, rnd: 1'b1, fill: 4'h0, toggle: 1'b0,
                 e_pulses: 8, e_lock: 1'b1, e_cyc: 48, e_shift: 0};
      tbl[5] = '{need: 2, rnd: 1'b1, fill: 4'h0, toggle: 1'b1,
                 e_pulses: 2, e_lock: 1'b1, e_cyc: 18, e_shift: 2};

      // Reset state
      tick();
      tick();
      check_idle("reset");
      check("reset shift", int'(shift_o), 0);
      rst_i = 1'b1;
      tick();
      check_idle("idle no start");

      for (int i = 0; i < 6; i++) apply($sformatf("vec%0d", i), tbl[i]);

      // Loss of lock: 3 bad + 1 good holds lock, then 4 bad
      run_align("loss", 0, 1'b1, 4'h0, 1'b0, p, l, c, s);
      check("loss initial lock", int'(l), 1);
      for (int i = 0; i < 3; i++) begin
         q_i = bad_word();
         tick();
         check($sformatf("loss hold bad%0d", i), int'(aligned_o), 1);
      end
      q_i = PAT;
      tick();
      check("loss hold good", int'(aligned_o), 1);
      for (int i = 0; i < 4; i++) begin
         q_i = bad_word();
         tick();
         if (i < 3) check($sformatf("loss bad%0d", i), int'(aligned_o), 1);
      end
`ifdef IDES4_ALIGN_RELOCK_EN
      check("relock calib", int'(calib_o), 1);
      check("relock aligned drop", int'(aligned_o), 0);
      q_i = PAT;
      n = 0;
      seen = 1'b0;
      for (int i = 1; i <= 50 && !seen; i++) begin
         tick();
         if (aligned_o) begin
            seen = 1'b1;
            n = i;
         end
      end
      check("relock cycles", n, 1 + SETTLE + MATCH);
      check("relock shift", int'(shift_o), 1);
`else
      check("loss fail", int'(fail_o), 1);
      check("loss calib", int'(calib_o), 0);
      check("loss aligned", int'(aligned_o), 0);
`endif
      end_run("loss");

      // Reset in the middle of a CALIB pulse
      q_i = 4'b0000;
      start_i = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         tick();
         if (calib_o) seen = 1'b1;
      end
      check("rst pulse seen", int'(seen), 1);
      #2 rst_i = 1'b0;
      #1;
      check_idle("rst in pulse");
      check("rst in pulse shift", int'(shift_o), 0);
      tick();
      check_idle("rst held");
      rst_i = 1'b1;
      run_align("post rst", 0, 1'b1, 4'h0, 1'b0, p, l, c, s);
      check("post rst locked", int'(l), 1);
      check("post rst cycle", c, MATCH);
      check("post rst pulses", p, 0);
      end_run("post rst");

      // Randomized slip depths against the timing model
      for (int t = 0; t < 12; t++) begin
         int need, e_p, e_c;
         need = int'($urandom_range(0, 10));
         for (int g = int'($urandom_range(0, 3)); g > 0; g--) tick();
         e_p = (need < MAXT) ? need : MAXT;
         e_c = (need <= MAXT) ? (SETTLE + 2) * need + MATCH : (SETTLE + 2) * MAXT + 1;
         run_align($sformatf("rnd%0d", t), need, 1'b1, 4'h0, 1'b0, p, l, c, s);
         check($sformatf("rnd%0d pulses", t), p, e_p);
         check($sformatf("rnd%0d locked", t), int'(l), int'(need <= MAXT));
         check($sformatf("rnd%0d cycle", t), c, e_c);
         check($sformatf("rnd%0d shift", t), s, e_p % 4);
         end_run($sformatf("rnd%0d", t));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
